// File: rtl/neuron_pkg.sv
// neuron_pkg: shared defaults, derived widths and FSM state type for the
// single-neuron multiply-accumulate block.
package neuron_pkg;

  // Default geometry of one neuron
  localparam int MAX_NEURONS_DEF = 10;
  localparam int WEIGHT_SIZE_DEF = 17;
  localparam int INPUT_SIZE_DEF  = 9;
  localparam int FRAC_BITS_DEF   = 8;
  localparam int ADDR_SIZE_DEF   = 10;

  // Full-precision signed product width
  function automatic int prod_width(input int w_bits, input int x_bits);
    return w_bits + x_bits;
  endfunction

  // Accumulator width: product plus enough guard bits for every lane summed
  function automatic int acc_width(input int w_bits, input int x_bits, input int lanes);
    return prod_width(w_bits, x_bits) + $clog2(lanes);
  endfunction

  // Lane counter width: must be able to hold the value MAX_NEURONS itself
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  localparam int PROD_W_DEF = prod_width(WEIGHT_SIZE_DEF, INPUT_SIZE_DEF);
  localparam int ACC_W_DEF  = acc_width(WEIGHT_SIZE_DEF, INPUT_SIZE_DEF, MAX_NEURONS_DEF);
  localparam int CNT_W_DEF  = cnt_width(MAX_NEURONS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/neuron_lut_addr.sv
// neuron_lut_addr: turns the raw dot-product accumulator into an activation
// LUT address: drop fractional bits (floor), re-centre around mid-table, then
// clamp (NEURON_SATURATE_EN defined) or keep the low address bits (default).
module neuron_lut_addr
  import neuron_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic [ACC_W-1:0]     acc,
  output logic [ADDR_SIZE-1:0] addr
);

  // Mid-table offset so that z = 0 lands in the middle of the LUT
  localparam logic signed [ACC_W-1:0] OFFSET   = ACC_W'(2 ** (ADDR_SIZE - 1));
  localparam logic signed [ACC_W-1:0] ADDR_MAX = ACC_W'(2 ** ADDR_SIZE - 1);

  logic signed [ACC_W-1:0] z;
  logic signed [ACC_W-1:0] a;

  // Rescale, offset and map into the address range
  always_comb begin
    z    = $signed(acc) >>> FRAC_BITS;
    a    = z + OFFSET;
    addr = a[ADDR_SIZE-1:0];
`ifdef NEURON_SATURATE_EN
    if (a[ACC_W-1]) begin
      addr = '0;
    end else if (a > ADDR_MAX) begin
      addr = '1;
    end
`endif
  end

`ifndef NEURON_SATURATE_EN
  // Upper bits are intentionally discarded when wrapping
  logic unused_hi;
  assign unused_hi = ^a[ACC_W-1:ADDR_SIZE];
`endif

endmodule

// File: rtl/neuron_top_core.sv
// neuron_top_core: sequential single-neuron MAC. Accumulates w[i]*x[i] for the
// first N lanes (one lane per clock), then registers the activation LUT address
// and pulses lut_valid for one cycle.
// Build option: NEURON_SATURATE_EN clamps the address instead of wrapping it.
module neuron_top_core
  import neuron_pkg::*;
#(
  parameter int MAX_NEURONS = MAX_NEURONS_DEF,
  parameter int WEIGHT_SIZE = WEIGHT_SIZE_DEF,
  parameter int INPUT_SIZE  = INPUT_SIZE_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int ADDR_SIZE   = ADDR_SIZE_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(MAX_NEURONS)-1:0]     input_signals,
  input  logic [MAX_NEURONS*WEIGHT_SIZE-1:0] weights,
  input  logic [MAX_NEURONS*INPUT_SIZE-1:0]  inputs,
  output logic [ADDR_SIZE-1:0]               addr,
  output logic                               lut_valid
);

  localparam int PROD_W = prod_width(WEIGHT_SIZE, INPUT_SIZE);
  localparam int ACC_W  = acc_width(WEIGHT_SIZE, INPUT_SIZE, MAX_NEURONS);
  localparam int CNT_W  = cnt_width(MAX_NEURONS);
  localparam logic [CNT_W-1:0] LANES = CNT_W'(MAX_NEURONS);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic               lut_valid_q, lut_valid_d;

  // Unpacked views of the live lane buses
  logic signed [WEIGHT_SIZE-1:0] w_lane [MAX_NEURONS];
  logic signed [INPUT_SIZE-1:0]  x_lane [MAX_NEURONS];

  for (genvar gi = 0; gi < MAX_NEURONS; gi++) begin : g_lane
    assign w_lane[gi] = weights[gi*WEIGHT_SIZE +: WEIGHT_SIZE];
    assign x_lane[gi] = inputs[gi*INPUT_SIZE +: INPUT_SIZE];
  end

  logic signed [WEIGHT_SIZE-1:0] w_sel;
  logic signed [INPUT_SIZE-1:0]  x_sel;
  logic signed [PROD_W-1:0]      prod;
  logic [ACC_W-1:0]              prod_ext;
  logic [CNT_W-1:0]              sig_ext;
  logic [CNT_W-1:0]              n_req;
  logic [ADDR_SIZE-1:0]          lut_addr;

  // Current-lane product and the clamped lane count requested by the caller
  always_comb begin
    w_sel    = w_lane[idx_q];
    x_sel    = x_lane[idx_q];
    prod     = w_sel * x_sel;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    sig_ext  = CNT_W'(input_signals);
    n_req    = (sig_ext > LANES) ? LANES : sig_ext;
  end

  neuron_lut_addr #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_lut_addr (
    .acc  (acc_q),
    .addr (lut_addr)
  );

  // Next-state and datapath updates for IDLE -> ACC -> DONE
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    n_d         = n_q;
    addr_d      = addr_q;
    lut_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = n_req;
          acc_d   = '0;
          idx_d   = '0;
          state_d = (n_req == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == n_q - 1'b1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        addr_d      = lut_addr;
        lut_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, lane counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      lut_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      lut_valid_q <= lut_valid_d;
    end
  end

  assign addr      = addr_q;
  assign lut_valid = lut_valid_q;

endmodule

// File: tb/tb_neuron_top_core.sv
// tb_neuron_top_core: randomized + directed scoreboard bench for neuron_top_core.
// Stimulus pushes {expected address, expected valid cycle}; a monitor pops on
// every lut_valid pulse and compares.
module tb_neuron_top_core;

  localparam int NL = 10;
  localparam int WS = 17;
  localparam int XS = 9;
  localparam int AS = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        input_signals = '0;
  logic [NL*WS-1:0]  weights = '0;
  logic [NL*XS-1:0]  inputs = '0;
  logic [AS-1:0]     addr;
  logic              lut_valid;

  always #5 clk = ~clk;

  neuron_top_core dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .input_signals (input_signals),
    .weights       (weights),
    .inputs        (inputs),
    .addr          (addr),
    .lut_valid     (lut_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    exp_addr;
    int    exp_cyc;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: plain integer dot product, floor divide, offset, clamp or wrap
  function automatic int ref_addr(input int n_req, input int w[NL], input int x[NL]);
    int     n;
    longint sum, r, z, a;
    n   = (n_req > NL) ? NL : n_req;
    sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(w[i]) * longint'(x[i]);
    r = sum % 256;
    if (r < 0) r += 256;
    z = (sum - r) / 256;
    a = z + 512;
`ifdef NEURON_SATURATE_EN
    if (a < 0) a = 0;
    if (a > 1023) a = 1023;
`else
    a = a % 1024;
    if (a < 0) a += 1024;
`endif
    return int'(a);
  endfunction

  task automatic load(input int w[NL], input int x[NL]);
    for (int i = 0; i < NL; i++) begin
      weights[i*WS +: WS] = WS'(w[i]);
      inputs[i*XS +: XS]  = XS'(x[i]);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  // One computation: start for a single edge, then scramble input_signals
  task automatic issue(input string tag, input int n, input int w[NL], input int x[NL],
                       input int exp_addr, input bit drain);
    int nn;
    @(negedge clk);
    load(w, x);
    input_signals = 4'(n);
    start = 1'b1;
    nn = (n > NL) ? NL : n;
    sb.push_back('{exp_addr, cyc + nn + 2, tag});
    @(negedge clk);
    start = 1'b0;
    input_signals = 4'($urandom_range(0, 15));
    if (drain) wait_drain(40);
  endtask

  // Monitor: every valid pulse must match the oldest expectation
  exp_t e;
  always @(negedge clk) begin
    if (rst && lut_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got addr %0d at cycle %0d, expected none", addr, cyc);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_addr"}, addr, e.exp_addr);
        check({e.tag, "_cycle"}, cyc, e.exp_cyc);
        $display("txn %s addr=%0d cycle=%0d", e.tag, addr, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[NL];
    int x[NL];
    int n, c0, ea;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_addr", addr, 0);
    check("reset_valid", lut_valid, 0);
    rst = 1'b1;

    // Reference vector
    w = '{512, 50, -7, -1024, 0, 0, 0, 0, 0, 0};
    x = '{128, -64, -12, 144, 0, 0, 0, 0, 0, 0};
    issue("ref_vec", 4, w, x, 179, 1'b1);

    // Zero length
    issue("zero_len", 0, w, x, 512, 1'b1);

    // Positive overflow
    w = '{65535, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    x = '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef NEURON_SATURATE_EN
    issue("pos_sat", 1, w, x, 1023, 1'b1);
`else
    issue("pos_sat", 1, w, x, 255, 1'b1);
`endif

    // Reset in the middle of an accumulation
    w = '{512, 50, -7, -1024, 0, 0, 0, 0, 0, 0};
    x = '{128, -64, -12, 144, 0, 0, 0, 0, 0, 0};
    issue("aborted", 4, w, x, 179, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midacc_reset_addr", addr, 0);
    check("midacc_reset_valid", lut_valid, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    issue("restart", 4, w, x, 179, 1'b1);

    // Negative overflow
    w = '{-65536, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    x = '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef NEURON_SATURATE_EN
    issue("neg_sat", 1, w, x, 0, 1'b1);
`else
    issue("neg_sat", 1, w, x, 768, 1'b1);
`endif

    // Lane clamp with start held (toggled randomly while busy)
    for (int i = 0; i < NL; i++) begin
      w[i] = 256;
      x[i] = 256;
    end
`ifdef NEURON_SATURATE_EN
    ea = 1023;
`else
    ea = 0;
`endif
    @(negedge clk);
    load(w, x);
    input_signals = 4'd15;
    c0 = cyc;
    sb.push_back('{ea, c0 + 12, "clamp0"});
    sb.push_back('{ea, c0 + 24, "clamp1"});
    sb.push_back('{ea, c0 + 36, "clamp2"});
    for (int d = 0; d < 36; d++) begin
      start = ((d % 12) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain(20);

    // Randomized vectors
    for (int t = 0; t < 24; t++) begin
      n = int'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) begin
        w[i] = int'($urandom_range(0, 131071)) - 65536;
        x[i] = int'($urandom_range(0, 511)) - 256;
        if ($urandom_range(0, 3) == 0) w[i] = w[i] / 64;
      end
      issue($sformatf("rnd%0d", t), n, w, x, ref_addr(n, w, x), 1'b1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neuron_top_core.md
# neuron_top_core

Single-neuron compute block for the layer-multiplexed network. Takes a packed vector of signed fixed-point weights and inputs and sequentially multiply-accumulates the first `input_signals` pairs, one pair per clock. It rescales the dot product to Q.8, offsets and saturates it into an activation look-up table address, then pulses `lut_valid`. It sits between the layer weight/input buffers and the activation (sigmoid) LUT.

## Interface
Parameters:
- `MAX_NEURONS`, default 10: number of weight/input lanes.
- `WEIGHT_SIZE`, default 17: signed weight width, Q.8 fixed point.
- `INPUT_SIZE`, default 9: signed input width, Q.8 fixed point.
- `FRAC_BITS`, default 8: fractional bits removed after multiply.
- `ADDR_SIZE`, default 10: LUT address width.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `start` input, 1: request a computation; sampled only in IDLE.
- `input_signals` input, $clog2(MAX_NEURONS)=4: number of active lanes N.
- `weights` input, MAX_NEURONS*WEIGHT_SIZE=170: lane i at `[i*WEIGHT_SIZE +: WEIGHT_SIZE]`.
- `inputs` input, MAX_NEURONS*INPUT_SIZE=90: lane i at `[i*INPUT_SIZE +: INPUT_SIZE]`.
- `addr` output, ADDR_SIZE=10: registered LUT address.
- `lut_valid` output, 1: one-cycle pulse when `addr` is updated.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: when `start`=1, latch N = min(`input_signals`, MAX_NEURONS), clear the accumulator, set lane index to 0, then go to ACC. If N=0, go directly to DONE.
- ACC: each cycle, add signed `w[idx]*x[idx]` to the accumulator.
  - Product width is 26 bits, signed.
  - Accumulator width is 30 bits, sized so it cannot overflow.
  - `idx` increments; after lane N-1, go to DONE.
- DONE:
  - z = acc >>> FRAC_BITS (arithmetic shift, floor).
  - a = z + 2^(ADDR_SIZE-1) = z + 512.
  - Register `addr` = a, saturated to [0, 1023].
  - Assert `lut_valid` for one cycle, then return to IDLE.
- `addr` holds its value until the next DONE.
- `start` outside IDLE is ignored. If `start` is held high, a new computation begins on the cycle after DONE.
- `weights`, `inputs` and `input_signals` are read live and must stay stable from `start` until `lut_valid`. N is latched, so `input_signals` may change after `start`.
- Reset (`rst`=0, any time, including mid-computation): state to IDLE, accumulator 0, `addr`=0, `lut_valid`=0.

## Timing
- Edge k samples `start` in IDLE.
- Edges k+1..k+N perform the N accumulations.
- Edge k+N+1 registers `addr` and sets `lut_valid`=1.
- `lut_valid` is high for exactly one cycle, between edges k+N+1 and k+N+2.
- Latency from start to valid is N+1 cycles; for N=0 it is 1 cycle, with `addr`=512.
- Back-to-back computations with `start` held high: one `lut_valid` every N+2 cycles.

## Configuration
- `NEURON_SATURATE_EN` defined: `addr` is clamped to [0, 2^ADDR_SIZE-1].
- Not defined: `addr` is the low ADDR_SIZE bits of a (wrap-around). All other behaviour is identical.

## Structure
- Package `neuron_pkg` holds:
  - the parameter defaults (MAX_NEURONS, WEIGHT_SIZE, INPUT_SIZE, FRAC_BITS, ADDR_SIZE);
  - derived widths (product, accumulator, count);
  - the state enum.
- One sub-module is natural: `neuron_lut_addr`, combinational. It takes the accumulator, applies shift, offset and saturate/wrap, and outputs the 10-bit address.
- FSM and MAC stay in the top.

## Test plan
- Reset: `rst`=0 mid-ACC -> `addr`=0, `lut_valid`=0 immediately; the next `start` restarts cleanly.
- Reference vector: N=4, w={512,50,-7,-1024}, x={128,-64,-12,144}.
  - Expect acc = -85036, z = -333, `addr` = 179.
  - `lut_valid` pulses exactly 5 cycles after the start edge.
- Zero length: N=0 -> `addr`=512 and `lut_valid` one cycle after start.
- Positive saturation: N=1, w=65535, x=255 -> z=65279.
  - With `NEURON_SATURATE_EN`: `addr`=1023.
  - Without: `addr`=255.
- Negative saturation: N=1, w=-65536, x=255 -> z=-65280 -> `addr`=0 (saturate).
- Clamp and continuous start: `input_signals`=15 with all lanes w=256, x=256.
  - 10 lanes are used: z=2560, which saturates to `addr`=1023.
  - With `start` held high, `lut_valid` repeats every 12 cycles.
  - `start` toggling mid-ACC has no effect.
